// File: rtl/exec_writeback.sv
// Writeback stage: commits execute results into the GPR file and EFLAGS, serialising XCHG-style dual writes.
// Optional macro WB_BYPASS_EN forwards the in-flight GPR write onto the read ports.
module exec_writeback #(
    parameter int          NUM_GPR      = 8,
    parameter logic [31:0] EFLAGS_RESET = 32'h0000_0002
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] opnd0_w,
    input  logic [31:0] opnd1_w,
    input  logic [31:0] eflags_w,
    input  logic        flags_en,
    input  logic        dst0_en,
    input  logic [2:0]  dst0_sel,
    input  logic        dst1_en,
    input  logic [2:0]  dst1_sel,
    input  logic [1:0]  opsize,
    input  logic [2:0]  rd_sel0,
    output logic [31:0] rd_data0,
    input  logic [2:0]  rd_sel1,
    output logic [31:0] rd_data1,
    output logic [31:0] eflags_q,
    output logic [31:0] retire_cnt,
    output logic        busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WR1  = 1'b1
    } state_e;

    localparam logic [1:0]  SIZE_8       = 2'b00;
    localparam logic [1:0]  SIZE_16      = 2'b01;
    localparam logic [31:0] EFLAGS_FIXED = 32'h0000_0002;

    state_e      state_q, state_d;
    logic [31:0] gpr_q [NUM_GPR];
    logic [31:0] opnd1_q, opnd1_d;
    logic [2:0]  dst1_sel_q, dst1_sel_d;
    logic [1:0]  opsize_q, opsize_d;
    logic [31:0] eflags_d;
    logic [31:0] retire_q;
    logic        retire;

    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [1:0]  wr_size;
    logic [31:0] wr_val;
    logic [2:0]  wr_idx;
    logic [31:0] wr_data;

    // 8-bit encodings 4..7 name the high byte (AH/CH/DH/BH) of registers 0..3.
    function automatic logic [2:0] phys_idx(input logic [2:0] sel, input logic [1:0] size);
        return (size == SIZE_8 && sel[2]) ? {1'b0, sel[1:0]} : sel;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] val,
                                          input logic [2:0] sel, input logic [1:0] size);
        logic [31:0] res;
        res = val;
        if (size == SIZE_8) begin
            res = sel[2] ? {cur[31:16], val[7:0], cur[7:0]} : {cur[31:8], val[7:0]};
        end else if (size == SIZE_16) begin
            res = {cur[31:16], val[15:0]};
        end
        return res;
    endfunction

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        opnd1_d    = opnd1_q;
        dst1_sel_d = dst1_sel_q;
        opsize_d   = opsize_q;
        eflags_d   = eflags_q;
        retire     = 1'b0;
        wr_en      = 1'b0;
        wr_sel     = dst0_sel;
        wr_val     = opnd0_w;
        wr_size    = opsize;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (dst0_en) begin
                        wr_en = 1'b1;
                    end else if (dst1_en) begin
                        wr_en  = 1'b1;
                        wr_sel = dst1_sel;
                        wr_val = opnd1_w;
                    end
                    if (flags_en) begin
                        eflags_d = eflags_w | EFLAGS_FIXED;
                    end
                    if (dst0_en && dst1_en) begin
                        state_d    = S_WR1;
                        opnd1_d    = opnd1_w;
                        dst1_sel_d = dst1_sel;
                        opsize_d   = opsize;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            S_WR1: begin
                wr_en   = 1'b1;
                wr_sel  = dst1_sel_q;
                wr_val  = opnd1_q;
                wr_size = opsize_q;
                retire  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_idx  = phys_idx(wr_sel, wr_size);
    assign wr_data = merge(gpr_q[wr_idx], wr_val, wr_sel, wr_size);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            opnd1_q    <= '0;
            dst1_sel_q <= '0;
            opsize_q   <= '0;
            eflags_q   <= EFLAGS_RESET;
            retire_q   <= '0;
        end else begin
            state_q    <= state_d;
            opnd1_q    <= opnd1_d;
            dst1_sel_q <= dst1_sel_d;
            opsize_q   <= opsize_d;
            eflags_q   <= eflags_d;
            if (retire) begin
                retire_q <= retire_q + 32'd1;
            end
        end
    end

    // NOTE: the register file is architecturally visible state, so it is cleared by reset like any flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (wr_en) begin
            gpr_q[wr_idx] <= wr_data;
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        rd_data0 = gpr_q[rd_sel0];
        rd_data1 = gpr_q[rd_sel1];
        if (wr_en && wr_idx == rd_sel0) begin
            rd_data0 = wr_data;
        end
        if (wr_en && wr_idx == rd_sel1) begin
            rd_data1 = wr_data;
        end
    end
`else
    assign rd_data0 = gpr_q[rd_sel0];
    assign rd_data1 = gpr_q[rd_sel1];
`endif

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q == S_WR1);
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_exec_writeback.sv
// Self-checking bench for exec_writeback: vector table, scoreboard of expected GPR values, reset/bypass sequences.
module tb_exec_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] opnd0_w, opnd1_w, eflags_w;
    logic        flags_en, dst0_en, dst1_en;
    logic [2:0]  dst0_sel, dst1_sel;
    logic [1:0]  opsize;
    logic [2:0]  rd_sel0, rd_sel1;
    logic [31:0] rd_data0, rd_data1, eflags_q, retire_cnt;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_retire;
    logic [31:0] exp_flags;

    typedef struct {
        logic        d0_en;
        logic [2:0]  d0_sel;
        logic        d1_en;
        logic [2:0]  d1_sel;
        logic [1:0]  size;
        logic [31:0] op0;
        logic [31:0] op1;
        logic        f_en;
        logic [31:0] fl_w;
        logic [2:0]  idx_a;
        logic [31:0] val_a;
        logic        b_en;
        logic [2:0]  idx_b;
        logic [31:0] val_b;
        logic [31:0] flags;
    } vec_t;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] val;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];

    exec_writeback dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opnd0_w    (opnd0_w),
        .opnd1_w    (opnd1_w),
        .eflags_w   (eflags_w),
        .flags_en   (flags_en),
        .dst0_en    (dst0_en),
        .dst0_sel   (dst0_sel),
        .dst1_en    (dst1_en),
        .dst1_sel   (dst1_sel),
        .opsize     (opsize),
        .rd_sel0    (rd_sel0),
        .rd_data0   (rd_data0),
        .rd_sel1    (rd_sel1),
        .rd_data1   (rd_data1),
        .eflags_q   (eflags_q),
        .retire_cnt (retire_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        dst0_en  = 1'b0;
        dst1_en  = 1'b0;
        flags_en = 1'b0;
        dst0_sel = '0;
        dst1_sel = '0;
        opsize   = 2'b10;
        opnd0_w  = '0;
        opnd1_w  = '0;
        eflags_w = '0;
    endtask

    function automatic vec_t mk(input logic d0_en, input logic [2:0] d0_sel, input logic d1_en,
                                input logic [2:0] d1_sel, input logic [1:0] size,
                                input logic [31:0] op0, input logic [31:0] op1,
                                input logic f_en, input logic [31:0] fl_w,
                                input logic [2:0] idx_a, input logic [31:0] val_a,
                                input logic b_en, input logic [2:0] idx_b, input logic [31:0] val_b,
                                input logic [31:0] flags);
        vec_t v;
        v.d0_en = d0_en; v.d0_sel = d0_sel; v.d1_en = d1_en; v.d1_sel = d1_sel;
        v.size = size; v.op0 = op0; v.op1 = op1; v.f_en = f_en; v.fl_w = fl_w;
        v.idx_a = idx_a; v.val_a = val_a; v.b_en = b_en; v.idx_b = idx_b; v.val_b = val_b;
        v.flags = flags;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < 8; r++) begin
            rd_sel0 = 3'(r);
            #1;
            check($sformatf("%s gpr%0d", tag, r), rd_data0, 32'h0);
        end
    endtask

    task automatic drain_sb(input string tag);
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rd_sel0 = e.idx;
            rd_sel1 = e.idx;
            #1;
            check($sformatf("%s rd0 gpr%0d", tag, e.idx), rd_data0, e.val);
            check($sformatf("%s rd1 gpr%0d", tag, e.idx), rd_data1, e.val);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        int  guard;
        sb_t e;
        logic dual;
        dual     = v.d0_en && v.d1_en;
        dst0_en  = v.d0_en;  dst0_sel = v.d0_sel;
        dst1_en  = v.d1_en;  dst1_sel = v.d1_sel;
        opsize   = v.size;   opnd0_w  = v.op0;  opnd1_w = v.op1;
        flags_en = v.f_en;   eflags_w = v.fl_w;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!in_ready) check({tag, " ready timeout"}, {31'b0, in_ready}, 32'h1);
        e.idx = v.idx_a; e.val = v.val_a;
        sb_q.push_back(e);
        if (v.b_en) begin
            e.idx = v.idx_b; e.val = v.val_b;
            sb_q.push_back(e);
        end
        exp_flags = v.flags;
        exp_retire = exp_retire + 32'd1;
        tick();
        if (dual) begin
            // Garbage held on the inputs during WR1 must be ignored entirely.
            dst0_en = 1'b0; dst1_en = 1'b0; flags_en = 1'b1; eflags_w = 32'hFFFF_FFFF;
            opsize  = 2'b10; opnd1_w = 32'hFFFF_FFFF; dst1_sel = 3'd6;
            check({tag, " wr1 busy"}, {31'b0, busy}, 32'h1);
            check({tag, " wr1 in_ready"}, {31'b0, in_ready}, 32'h0);
            tick();
        end
        idle_inputs();
        check({tag, " busy"}, {31'b0, busy}, 32'h0);
        check({tag, " in_ready"}, {31'b0, in_ready}, 32'h1);
        drain_sb(tag);
        check({tag, " eflags"}, eflags_q, exp_flags);
        check({tag, " retire"}, retire_cnt, exp_retire);
    endtask

    initial begin
        idle_inputs();
        rd_sel0 = '0;
        rd_sel1 = '0;
        rst_n = 1'b0;
        exp_retire = '0;
        exp_flags  = 32'h2;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        check("por eflags", eflags_q, 32'h2);
        check("por retire", retire_cnt, 32'h0);
        check("por in_ready", {31'b0, in_ready}, 32'h1);
        check("por busy", {31'b0, busy}, 32'h0);
        check_all_zero("por");

        // Reset asserted while the second half of an XCHG is pending.
        dst0_en = 1'b1; dst0_sel = 3'd0; opnd0_w = 32'h77;
        dst1_en = 1'b1; dst1_sel = 3'd3; opnd1_w = 32'h88;
        opsize = 2'b10; flags_en = 1'b1; eflags_w = 32'h0000_0800;
        in_valid = 1'b1;
        tick();
        idle_inputs();
        check("pre-rst busy", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        check("rst eflags", eflags_q, 32'h2);
        check("rst retire", retire_cnt, 32'h0);
        check("rst in_ready", {31'b0, in_ready}, 32'h1);
        check("rst busy", {31'b0, busy}, 32'h0);
        check_all_zero("rst");

        //          d0 s0    d1 s1    size   op0            op1            fen fl_w            idx_a val_a          b  idx_b val_b     flags
        vecs.push_back(mk(1, 3'd0, 0, 3'd0, 2'b10, 32'hDEADBEEF, 32'h0,        1, 32'h0000_0041, 3'd0, 32'hDEADBEEF, 0, 3'd0, 32'h0,    32'h43));
        vecs.push_back(mk(1, 3'd1, 0, 3'd0, 2'b10, 32'h11223344, 32'h0,        0, 32'h0,         3'd1, 32'h11223344, 0, 3'd0, 32'h0,    32'h43));
        vecs.push_back(mk(1, 3'd5, 0, 3'd0, 2'b00, 32'hFFFFFFAA, 32'h0,        0, 32'h0,         3'd1, 32'h1122AA44, 0, 3'd0, 32'h0,    32'h43));
        vecs.push_back(mk(1, 3'd1, 0, 3'd0, 2'b01, 32'h5555BEEF, 32'h0,        0, 32'h0,         3'd1, 32'h1122BEEF, 0, 3'd0, 32'h0,    32'h43));
        vecs.push_back(mk(1, 3'd1, 0, 3'd0, 2'b00, 32'h00000077, 32'h0,        0, 32'h0,         3'd1, 32'h1122BE77, 0, 3'd0, 32'h0,    32'h43));
        vecs.push_back(mk(1, 3'd2, 0, 3'd0, 2'b11, 32'hCAFEF00D, 32'h0,        0, 32'h0,         3'd2, 32'hCAFEF00D, 0, 3'd0, 32'h0,    32'h43));
        vecs.push_back(mk(0, 3'd3, 1, 3'd3, 2'b10, 32'h99999999, 32'h2,        1, 32'hFFFFFFFD,  3'd3, 32'h00000002, 0, 3'd0, 32'h0,    32'hFFFFFFFF));
        vecs.push_back(mk(1, 3'd7, 0, 3'd0, 2'b00, 32'h0000005A, 32'h0,        0, 32'h0,         3'd3, 32'h00005A02, 0, 3'd0, 32'h0,    32'hFFFFFFFF));
        vecs.push_back(mk(1, 3'd0, 0, 3'd0, 2'b01, 32'h00001234, 32'h0,        0, 32'h0,         3'd0, 32'hDEAD1234, 0, 3'd0, 32'h0,    32'hFFFFFFFF));
        vecs.push_back(mk(0, 3'd0, 0, 3'd0, 2'b10, 32'h0BAD0BAD, 32'h0BAD0BAD, 0, 32'h0,         3'd0, 32'hDEAD1234, 0, 3'd0, 32'h0,    32'hFFFFFFFF));
        vecs.push_back(mk(0, 3'd0, 0, 3'd0, 2'b10, 32'h0,        32'h0,        1, 32'h0,         3'd0, 32'hDEAD1234, 0, 3'd0, 32'h0,    32'h2));
        vecs.push_back(mk(1, 3'd0, 0, 3'd0, 2'b10, 32'h1,        32'h0,        0, 32'h0,         3'd0, 32'h1,        0, 3'd0, 32'h0,    32'h2));
        vecs.push_back(mk(1, 3'd3, 0, 3'd0, 2'b10, 32'h2,        32'h0,        0, 32'h0,         3'd3, 32'h2,        0, 3'd0, 32'h0,    32'h2));
        vecs.push_back(mk(1, 3'd0, 1, 3'd3, 2'b10, 32'h2,        32'h1,        0, 32'h0,         3'd0, 32'h2,        1, 3'd3, 32'h1,    32'h2));
        vecs.push_back(mk(1, 3'd2, 1, 3'd2, 2'b10, 32'h5,        32'h9,        0, 32'h0,         3'd2, 32'h9,        0, 3'd0, 32'h0,    32'h2));
        vecs.push_back(mk(1, 3'd4, 1, 3'd0, 2'b00, 32'h11,       32'h22,       0, 32'h0,         3'd0, 32'h1122,     1, 3'd3, 32'h1,    32'h2));
        vecs.push_back(mk(1, 3'd6, 1, 3'd7, 2'b01, 32'hAAAA7777, 32'h00004321, 1, 32'h00000880,  3'd6, 32'h7777,     1, 3'd7, 32'h4321, 32'h882));

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Same-cycle read of a register being written: forwarded only with the bypass build.
        rd_sel0 = 3'd2;
        rd_sel1 = 3'd2;
        dst0_en = 1'b1; dst0_sel = 3'd2; opsize = 2'b10; opnd0_w = 32'h1234;
        in_valid = 1'b1;
        #1;
`ifdef WB_BYPASS_EN
        check("byp32 same-cycle", rd_data0, 32'h1234);
`else
        check("byp32 same-cycle", rd_data0, 32'h9);
`endif
        tick();
        exp_retire = exp_retire + 32'd1;
        check("byp32 next-cycle", rd_data0, 32'h1234);
        dst0_sel = 3'd6; opsize = 2'b00; opnd0_w = 32'hAB;
        #1;
`ifdef WB_BYPASS_EN
        check("byp8 same-cycle", rd_data1, 32'hAB34);
`else
        check("byp8 same-cycle", rd_data1, 32'h1234);
`endif
        tick();
        idle_inputs();
        exp_retire = exp_retire + 32'd1;
        check("byp8 next-cycle", rd_data1, 32'hAB34);
        check("final retire", retire_cnt, exp_retire);
        check("final eflags", eflags_q, 32'h882);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
